// File: rtl/wb_regfile_if.sv
// Write-back to register-file bundle: WB-stage write request, ID-stage read
// indices, and the read data / write counter returned by the register file.
interface wb_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  RegWrite_In;
    logic [ADDR_WIDTH-1:0] WriteReg_In;
    logic [DATA_WIDTH-1:0] WriteData_In;
    logic [ADDR_WIDTH-1:0] ReadReg1_In;
    logic [ADDR_WIDTH-1:0] ReadReg2_In;
    logic [DATA_WIDTH-1:0] ReadData1_Out;
    logic [DATA_WIDTH-1:0] ReadData2_Out;
    logic [CNT_WIDTH-1:0]  WriteCount_Out;

    modport master (
        output RegWrite_In, WriteReg_In, WriteData_In, ReadReg1_In, ReadReg2_In,
        input  ReadData1_Out, ReadData2_Out, WriteCount_Out
    );

    modport slave (
        input  RegWrite_In, WriteReg_In, WriteData_In, ReadReg1_In, ReadReg2_In,
        output ReadData1_Out, ReadData2_Out, WriteCount_Out
    );
endinterface

// File: rtl/wb_regfile.sv
// Two-read/one-write register file with hardwired zero register, same-cycle
// write-to-read bypass and a saturating count of committed writes.
module wb_regfile #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    SP_INDEX   = 29,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_03FC,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    wb_regfile_if.slave   bus
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_d;
    logic                  wr_en;

    // A write commits only outside reset and never to the zero register.
    assign wr_en = !Reset && bus.RegWrite_In && (bus.WriteReg_In != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.WriteReg_In] = bus.WriteData_In;
        end
        regs_d[0] = '0;
    end

    always_comb begin
        count_d = count_q;
        if (wr_en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_INIT : '0;
            end
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    logic [1:0][ADDR_WIDTH-1:0] rd_addr;
    assign rd_addr = {bus.ReadReg2_In, bus.ReadReg1_In};

    // Each read port independently forwards the in-flight write data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] rd_data;
            assign rd_data = (rd_addr[gi] == '0)                             ? '0 :
                             (wr_en && (bus.WriteReg_In == rd_addr[gi]))     ? bus.WriteData_In :
                                                                               regs_q[rd_addr[gi]];
        end
    endgenerate

    assign bus.ReadData1_Out  = g_rd[0].rd_data;
    assign bus.ReadData2_Out  = g_rd[1].rd_data;
    assign bus.WriteCount_Out = count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized check of wb_regfile against an array/integer reference model;
// a CNT_WIDTH=2 twin shares the stimulus to exercise counter saturation.
module tb_wb_regfile;
    logic clk;
    logic rst;

    wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();
    wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2))  bus2 ();

    assign bus2.RegWrite_In  = bus.RegWrite_In;
    assign bus2.WriteReg_In  = bus.WriteReg_In;
    assign bus2.WriteData_In = bus.WriteData_In;
    assign bus2.ReadReg1_In  = bus.ReadReg1_In;
    assign bus2.ReadReg2_In  = bus.ReadReg2_In;

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SP_INDEX(29),
                 .SP_INIT(32'h0000_03FC), .CNT_WIDTH(16)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SP_INDEX(29),
                 .SP_INIT(32'h0000_03FC), .CNT_WIDTH(2)) dut_sat (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned step_no  = 0;

    logic [31:0] m_regs [32];
    int unsigned m_cnt16;
    int unsigned m_cnt2;
    bit          m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic r, input logic we, input logic [4:0] wa,
                                               input logic [31:0] wd, input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (!r && we && wa != 5'd0 && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input string tag);
        @(negedge clk);
        rst              = r;
        bus.RegWrite_In  = we;
        bus.WriteReg_In  = wa;
        bus.WriteData_In = wd;
        bus.ReadReg1_In  = r1;
        bus.ReadReg2_In  = r2;
        #2;
        step_no++;
        $display("step %0d %s rst=%0b we=%0b wa=%0d wd=%h r1=%0d r2=%0d -> d1=%h d2=%h cnt=%0d",
                 step_no, tag, r, we, wa, wd, r1, r2,
                 bus.ReadData1_Out, bus.ReadData2_Out, bus.WriteCount_Out);
        if (m_valid) begin
            check({tag, "/rd1"}, bus.ReadData1_Out, model_read(r, we, wa, wd, r1));
            check({tag, "/rd2"}, bus.ReadData2_Out, model_read(r, we, wa, wd, r2));
            check({tag, "/cnt16"}, 32'(bus.WriteCount_Out), m_cnt16);
            check({tag, "/cnt2"}, 32'(bus2.WriteCount_Out), m_cnt2);
            check({tag, "/sat_rd1"}, bus2.ReadData1_Out, model_read(r, we, wa, wd, r1));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_regs[29] = 32'h0000_03FC;
            m_cnt16    = 0;
            m_cnt2     = 0;
            m_valid    = 1'b1;
        end else if (we && wa != 5'd0) begin
            m_regs[wa] = wd;
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    initial begin
        logic [4:0]  wa;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        r;
        logic        we;
        rst              = 1'b1;
        bus.RegWrite_In  = 1'b0;
        bus.WriteReg_In  = '0;
        bus.WriteData_In = '0;
        bus.ReadReg1_In  = '0;
        bus.ReadReg2_In  = '0;

        step(1, 0, 0, 0, 0, 29, "reset");
        step(0, 0, 0, 0, 1, 29, "post_reset");
        step(0, 1, 5, 32'd2, 0, 0, "wr5");
        step(0, 0, 0, 0, 5, 5, "rd5");
        step(0, 1, 7, 32'hDEAD_BEEF, 7, 7, "byp7");
        step(0, 0, 0, 0, 7, 7, "rd7");
        step(0, 1, 0, 32'd99, 0, 0, "wr0");
        step(0, 0, 0, 0, 0, 0, "rd0");
        step(0, 0, 3, 32'd5, 3, 3, "nowe3");
        step(0, 0, 0, 0, 3, 5, "rd3");
        step(1, 1, 4, 32'd8, 4, 7, "rst_wr4");
        step(0, 1, 4, 32'd11, 4, 7, "first_wr");
        step(0, 1, 6, 32'd1, 4, 6, "sat1");
        step(0, 1, 8, 32'd2, 6, 8, "sat2");
        step(0, 1, 9, 32'd3, 8, 9, "sat3");
        step(0, 1, 10, 32'd4, 9, 10, "sat4");
        step(0, 0, 0, 0, 10, 29, "sat_hold");

        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step(r, we, wa, $urandom, r1, r2, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
